// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_mem_arbiter: two-master, single-slave front end for a DataMemory port
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_en,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wd,
  output logic [DATA_W-1:0] m0_rd,
  output logic              m0_stall,
  input  logic              m1_en,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wd,
  output logic [DATA_W-1:0] m1_rd,
  output logic              m1_stall,
  output logic              s_en,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wd,
  input  logic [DATA_W-1:0] s_rd,
  input  logic              s_stall
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                prio;
  logic                grant;
  logic                pick;
  logic                any_req;
  logic                done0;
  logic                done1;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wd;
  logic [DATA_W-1:0]   rd0;
  logic [DATA_W-1:0]   rd1;

  assign any_req = m0_en | m1_en;
  // Contention goes to the priority pointer; otherwise the lone requester wins.
  assign pick    = (m0_en & m1_en) ? prio : m1_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    s_en       = 1'b0;
    case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE: begin
        s_en       = 1'b1;
        state_next = WAIT;
      end
      WAIT:    if (!s_stall) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prio     <= 1'b0;
      grant    <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      req_we   <= 1'b0;
      req_addr <= '0;
      req_wd   <= '0;
      rd0      <= '0;
      rd1      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant    <= pick;
            req_we   <= pick ? m1_we   : m0_we;
            req_addr <= pick ? m1_addr : m0_addr;
            req_wd   <= pick ? m1_wd   : m0_wd;
          end
        end
        WAIT: begin
          // Read data is captured on writes too; the master simply ignores it.
          if (!s_stall) begin
            if (grant) begin
              rd1   <= s_rd;
              done1 <= 1'b1;
            end else begin
              rd0   <= s_rd;
              done0 <= 1'b1;
            end
          end
        end
        DONE: begin
          if (grant) begin
            done1 <= 1'b0;
          end else begin
            done0 <= 1'b0;
          end
          prio <= ~grant;
        end
        default: ;
      endcase
    end
  end

  assign m0_stall = m0_en & ~done0;
  assign m1_stall = m1_en & ~done1;
  assign m0_rd    = rd0;
  assign m1_rd    = rd1;
  assign s_we     = req_we;
  assign s_addr   = req_addr;
  assign s_wd     = req_wd;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// Directed bench for data_mem_arbiter with a switchable BRAM / DDR2-style slave.
module tb_data_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int DDR_N   = 11;

  logic              clock;
  logic              reset;
  logic              m0_en, m0_we, m1_en, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wd, m1_wd, m0_rd, m1_rd;
  logic              m0_stall, m1_stall;
  logic              s_en, s_we, s_stall;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wd, s_rd;

  logic              ddr_mode;
  logic [DATA_W-1:0] mem [16];
  int                cnt;
  int                tests;
  int                fails;

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock   (clock),
    .reset   (reset),
    .m0_en   (m0_en),
    .m0_we   (m0_we),
    .m0_addr (m0_addr),
    .m0_wd   (m0_wd),
    .m0_rd   (m0_rd),
    .m0_stall(m0_stall),
    .m1_en   (m1_en),
    .m1_we   (m1_we),
    .m1_addr (m1_addr),
    .m1_wd   (m1_wd),
    .m1_rd   (m1_rd),
    .m1_stall(m1_stall),
    .s_en    (s_en),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wd    (s_wd),
    .s_rd    (s_rd),
    .s_stall (s_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave: memory preloaded with address-tagged words on reset, mem[5] special.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      mem[5] <= 32'hDEAD_BEEF;
      cnt    <= 0;
    end else begin
      if (s_en && s_we) mem[s_addr[3:0]] <= s_wd;
      if (s_en) cnt <= DDR_N;
      else if (cnt > 0) cnt <= cnt - 1;
    end
  end
  assign s_rd    = mem[s_addr[3:0]];
  assign s_stall = ddr_mode && (cnt != 0);

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    m0_en = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wd = '0;
    m1_en = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wd = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    step();
    reset = 1'b1; m0_en = 1'b1; m1_en = 1'b1; m0_addr = 32'd5;
    step();
    sample();
    tests++; if (s_en !== 1'b0) begin fails++; $display("FAIL reset_s_en got %b exp 0", s_en); end
    tests++; if (m0_stall !== 1'b1) begin fails++; $display("FAIL reset_m0_stall got %b exp 1", m0_stall); end
    tests++; if (m1_stall !== 1'b1) begin fails++; $display("FAIL reset_m1_stall got %b exp 1", m1_stall); end
    tests++; if (m0_rd !== 32'h0) begin fails++; $display("FAIL reset_m0_rd got %h exp 0", m0_rd); end
    tests++; if (m1_rd !== 32'h0) begin fails++; $display("FAIL reset_m1_rd got %h exp 0", m1_rd); end
    tests++; if (s_addr !== 32'h0) begin fails++; $display("FAIL reset_s_addr got %h exp 0", s_addr); end
    step();
    m0_en = 1'b0;
    sample();
    tests++; if (m0_stall !== 1'b0) begin fails++; $display("FAIL reset_m0_stall_off got %b exp 0", m0_stall); end
    tests++; if (m1_stall !== 1'b1) begin fails++; $display("FAIL reset_m1_stall_on got %b exp 1", m1_stall); end
    m1_en = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_bram_read();
    logic exp_sen, exp_stall;
    do_reset(); ddr_mode = 1'b0;
    step();
    m0_en = 1'b1; m0_we = 1'b0; m0_addr = 32'd5;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step();
      sample();
      exp_sen   = (c == 1);
      exp_stall = (c != 3);
      tests++; if (s_en !== exp_sen) begin fails++; $display("FAIL bram_s_en c=%0d got %b exp %b", c, s_en, exp_sen); end
      tests++; if (m0_stall !== exp_stall) begin fails++; $display("FAIL bram_m0_stall c=%0d got %b exp %b", c, m0_stall, exp_stall); end
    end
    tests++; if (m0_rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL bram_m0_rd got %h exp deadbeef", m0_rd); end
    tests++; if (m1_rd !== 32'h0) begin fails++; $display("FAIL bram_m1_rd got %h exp 0", m1_rd); end
    step();
    m0_en = 1'b0;
  endtask

  task automatic test_ddr_write_read();
    int k;
    do_reset(); ddr_mode = 1'b1;
    step();
    m1_en = 1'b1; m1_we = 1'b1; m1_addr = 32'd7; m1_wd = 32'h1234_5678;
    sample();
    k = 0;
    while (m1_stall && k < 40) begin step(); sample(); k++; end
    tests++; if (k !== 14) begin fails++; $display("FAIL ddr_write_latency got %0d exp 14", k); end
    step();
    m1_we = 1'b0; m1_wd = '0;
    sample();
    k = 0;
    while (m1_stall && k < 40) begin step(); sample(); k++; end
    tests++; if (k !== 14) begin fails++; $display("FAIL ddr_read_latency got %0d exp 14", k); end
    tests++; if (m1_rd !== 32'h1234_5678) begin fails++; $display("FAIL ddr_read_data got %h exp 12345678", m1_rd); end
    tests++; if (m0_rd !== 32'h0) begin fails++; $display("FAIL ddr_m0_rd got %h exp 0", m0_rd); end
    step();
    m1_en = 1'b0;
  endtask

  task automatic test_alternate();
    int k, got, i0, i1;
    do_reset(); ddr_mode = 1'b0;
    i0 = 0; i1 = 0;
    step();
    m0_en = 1'b1; m0_we = 1'b0; m0_addr = 32'd1;
    m1_en = 1'b1; m1_we = 1'b0; m1_addr = 32'd9;
    for (int n = 0; n < 6; n++) begin
      sample();
      k = 0;
      while (!((m0_en && !m0_stall) || (m1_en && !m1_stall)) && k < 20) begin
        step(); sample(); k++;
      end
      got = (m0_en && !m0_stall) ? 0 : ((m1_en && !m1_stall) ? 1 : 2);
      tests++; if (got !== (n % 2)) begin fails++; $display("FAIL alt_grant n=%0d got %0d exp %0d", n, got, n % 2); end
      tests++; if (k !== 3) begin fails++; $display("FAIL alt_latency n=%0d got %0d exp 3", n, k); end
      if (got == 0) begin
        tests++; if (m0_rd !== (32'hA000_0000 | m0_addr)) begin fails++; $display("FAIL alt_m0_rd n=%0d got %h exp %h", n, m0_rd, 32'hA000_0000 | m0_addr); end
        step();
        i0++;
        if (i0 == 3) m0_en = 1'b0; else m0_addr = 32'(1 + i0);
      end else begin
        tests++; if (m1_rd !== (32'hA000_0000 | m1_addr)) begin fails++; $display("FAIL alt_m1_rd n=%0d got %h exp %h", n, m1_rd, 32'hA000_0000 | m1_addr); end
        step();
        i1++;
        if (i1 == 3) m1_en = 1'b0; else m1_addr = 32'(9 + i1);
      end
    end
    m0_en = 1'b0; m1_en = 1'b0;
  endtask

  task automatic test_late_request();
    int k;
    do_reset(); ddr_mode = 1'b1;
    step();
    m0_en = 1'b1; m0_we = 1'b0; m0_addr = 32'd5;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) step();
      if (c == 4)  begin m1_en = 1'b1; m1_we = 1'b0; m1_addr = 32'd9; end
      if (c == 15) m0_en = 1'b0;
      sample();
      if (c >= 4 && c <= 14) begin
        tests++; if (m1_stall !== 1'b1) begin fails++; $display("FAIL late_m1_stall c=%0d got %b exp 1", c, m1_stall); end
      end
      if (c == 14) begin
        tests++; if (m0_stall !== 1'b0) begin fails++; $display("FAIL late_m0_done got %b exp 0", m0_stall); end
        tests++; if (m0_rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL late_m0_rd got %h exp deadbeef", m0_rd); end
      end
      if (c == 15) begin
        tests++; if (s_en !== 1'b0) begin fails++; $display("FAIL late_s_en_idle got %b exp 0", s_en); end
      end
      if (c == 16) begin
        tests++; if (s_en !== 1'b1) begin fails++; $display("FAIL late_m1_issue got %b exp 1", s_en); end
        tests++; if (s_addr !== 32'd9) begin fails++; $display("FAIL late_m1_addr got %h exp 9", s_addr); end
      end
    end
    k = 16;
    while (m1_stall && k < 60) begin step(); sample(); k++; end
    tests++; if (k !== 29) begin fails++; $display("FAIL late_m1_latency got %0d exp 29", k); end
    tests++; if (m1_rd !== 32'hA000_0009) begin fails++; $display("FAIL late_m1_rd got %h exp a0000009", m1_rd); end
    tests++; if (m0_rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL late_m0_rd_hold got %h exp deadbeef", m0_rd); end
    step();
    m1_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k;
    do_reset(); ddr_mode = 1'b1;
    step();
    m0_en = 1'b1; m0_we = 1'b0; m0_addr = 32'd2;
    sample();
    k = 0;
    while (m0_stall && k < 40) begin step(); sample(); k++; end
    tests++; if (m0_rd !== 32'hA000_0002) begin fails++; $display("FAIL rstmid_first_rd got %h exp a0000002", m0_rd); end
    step();
    m0_addr = 32'd3;
    for (int c = 1; c <= 5; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sample();
    tests++; if (s_en !== 1'b0) begin fails++; $display("FAIL rstmid_s_en got %b exp 0", s_en); end
    tests++; if (m0_rd !== 32'h0) begin fails++; $display("FAIL rstmid_m0_rd got %h exp 0", m0_rd); end
    tests++; if (m1_rd !== 32'h0) begin fails++; $display("FAIL rstmid_m1_rd got %h exp 0", m1_rd); end
    tests++; if (m0_stall !== 1'b1) begin fails++; $display("FAIL rstmid_m0_stall got %b exp 1", m0_stall); end
    k = 0;
    while (m0_stall && k < 40) begin step(); sample(); k++; end
    tests++; if (k !== 14) begin fails++; $display("FAIL rstmid_fresh_latency got %0d exp 14", k); end
    tests++; if (m0_rd !== 32'hA000_0003) begin fails++; $display("FAIL rstmid_fresh_rd got %h exp a0000003", m0_rd); end
    step();
    m0_en = 1'b0;
  endtask

  task automatic test_drop_en();
    int k;
    do_reset(); ddr_mode = 1'b1;
    step();
    m0_en = 1'b1; m0_we = 1'b0; m0_addr = 32'd4;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) step();
      if (c == 4) begin
        m0_en = 1'b0;
        m1_en = 1'b1; m1_we = 1'b0; m1_addr = 32'd10;
      end
      sample();
      if (c >= 4 && c <= 15) begin
        tests++; if (m1_stall !== 1'b1) begin fails++; $display("FAIL drop_m1_stall c=%0d got %b exp 1", c, m1_stall); end
      end
      if (c == 14) begin
        tests++; if (m0_rd !== 32'hA000_0004) begin fails++; $display("FAIL drop_m0_rd got %h exp a0000004", m0_rd); end
      end
      if (c == 16) begin
        tests++; if (s_en !== 1'b1) begin fails++; $display("FAIL drop_m1_issue got %b exp 1", s_en); end
        tests++; if (s_addr !== 32'd10) begin fails++; $display("FAIL drop_m1_addr got %h exp a", s_addr); end
      end
    end
    k = 16;
    while (m1_stall && k < 60) begin step(); sample(); k++; end
    tests++; if (k !== 29) begin fails++; $display("FAIL drop_m1_latency got %0d exp 29", k); end
    tests++; if (m1_rd !== 32'hA000_000A) begin fails++; $display("FAIL drop_m1_rd got %h exp a000000a", m1_rd); end
    step();
    m1_en = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; ddr_mode = 1'b0;
    reset = 1'b1;
    m0_en = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wd = '0;
    m1_en = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wd = '0;
    test_reset();
    test_bram_read();
    test_ddr_write_read();
    test_alternate();
    test_late_request();
    test_reset_mid();
    test_drop_en();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1);
  end

endmodule
`default_nettype wire
